// File: rtl/bcd_display_pkg.sv
// Purpose : shared types and constants for the two-digit BCD seven-segment scanner.
// Latency : n/a (types, constants and a pure function only).
// Backpressure: n/a.
//
// Contents:
//   scan_state_t  - refresh FSM states (ones slot, gap, tens slot, gap)
//   SEG_* / AN_*  - active-low segment and anode patterns
//   digit_pattern - nibble to active-high {g,f,e,d,c,b,a} pattern
package bcd_display_pkg;

  typedef enum logic [1:0] {
    S_ONES = 2'd0,
    S_GAP1 = 2'd1,
    S_TENS = 2'd2,
    S_GAP2 = 2'd3
  } scan_state_t;

  // Active-low segment words {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Active-low anode words; an[0] drives the ones digit, an[1] the tens digit
  localparam logic [1:0] AN_OFF  = 2'b11;
  localparam logic [1:0] AN_ONES = 2'b10;
  localparam logic [1:0] AN_TENS = 2'b01;

  // Active-high segment pattern for one nibble. Anything that is not a
  // decimal digit lights only segment g so corrupt input shows as a dash.
  function automatic logic [6:0] digit_pattern(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'd0:    pat = 7'h3F;
      4'd1:    pat = 7'h06;
      4'd2:    pat = 7'h5B;
      4'd3:    pat = 7'h4F;
      4'd4:    pat = 7'h66;
      4'd5:    pat = 7'h6D;
      4'd6:    pat = 7'h7D;
      4'd7:    pat = 7'h07;
      4'd8:    pat = 7'h7F;
      4'd9:    pat = 7'h6F;
      default: pat = 7'h40;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Purpose : decode one BCD nibble to an active-low seven-segment word.
// Latency : combinational, zero cycles.
// Backpressure: none; pure function of the input.
//
// Ports:
//   digit  in  4  BCD nibble (10-15 are shown as a dash)
//   seg_n  out 7  active-low segments {g,f,e,d,c,b,a}
module bcd_to_7seg
  import bcd_display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg_n
);

  // The display is common-anode, so a lit segment is a low output.
  always_comb begin
    seg_n = ~digit_pattern(digit);
  end

endmodule

// File: rtl/bcd_display_mux.sv
// Purpose : time-multiplexed two-digit common-anode display driver for packed BCD.
// Latency : load visible on seg one cycle after capture; seg/an/dp/frame registered (1 cycle behind FSM).
// Backpressure: none; load is a capture strobe, the scan free-runs and never stalls.
//
// Ports:
//   clk     in   1  system clock
//   reset   in   1  synchronous, active-high reset
//   bcd_in  in   8  packed BCD, [7:4] tens, [3:0] ones
//   load    in   1  capture bcd_in into the holding register this edge
//   seg     out  7  active-low segments {g,f,e,d,c,b,a}
//   dp      out  1  active-low decimal point, held off
//   an      out  2  active-low anodes, an[0] ones, an[1] tens
//   frame   out  1  one-cycle pulse marking the end of a full scan
//
// Build option: define LEADING_ZERO_BLANK_EN to blank the tens digit when it is
// zero (the slot still takes its full dwell time, anodes simply stay off).
module bcd_display_mux
  import bcd_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 16,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] bcd_in,
  input  logic       load,
  output logic [6:0] seg,
  output logic       dp,
  output logic [1:0] an,
  output logic       frame
);

  // Terminal counts for the two kinds of slot
  localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

  logic [7:0]       hold;
  scan_state_t      state;
  scan_state_t      state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             slot_last;

  logic [3:0]       dec_digit;
  logic [6:0]       dec_seg;

  logic [6:0]       seg_nxt;
  logic [1:0]       an_nxt;
  logic             frame_nxt;

  // ---------------------------------------------------------------------------
  // Scan sequencing: each state dwells until its counter reaches the last
  // cycle of the slot, then the counter clears on the same edge it advances.
  // ---------------------------------------------------------------------------
  always_comb begin
    slot_last = 1'b0;
    case (state)
      S_ONES, S_TENS: slot_last = (cnt == DIGIT_LAST);
      S_GAP1, S_GAP2: slot_last = (cnt == GAP_LAST);
      default:        slot_last = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt = state;
    if (slot_last) begin
      case (state)
        S_ONES:  state_nxt = S_GAP1;
        S_GAP1:  state_nxt = S_TENS;
        S_TENS:  state_nxt = S_GAP2;
        S_GAP2:  state_nxt = S_ONES;
        default: state_nxt = S_ONES;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Single shared decoder; the nibble is chosen by the slot being lit.
  // Outputs are computed from the current holding value, so a load on edge N
  // shows up on the outputs registered at edge N+1.
  // ---------------------------------------------------------------------------
  always_comb begin
    dec_digit = (state == S_TENS) ? hold[7:4] : hold[3:0];
  end

  bcd_to_7seg u_dec (
    .digit (dec_digit),
    .seg_n (dec_seg)
  );

  always_comb begin
    seg_nxt = SEG_BLANK;
    an_nxt  = AN_OFF;
    case (state)
      S_ONES: begin
        an_nxt  = AN_ONES;
        seg_nxt = dec_seg;
      end
      S_TENS: begin
`ifdef LEADING_ZERO_BLANK_EN
        if (hold[7:4] == 4'd0) begin
          an_nxt  = AN_OFF;
          seg_nxt = SEG_BLANK;
        end else begin
          an_nxt  = AN_TENS;
          seg_nxt = dec_seg;
        end
`else
        an_nxt  = AN_TENS;
        seg_nxt = dec_seg;
`endif
      end
      // Both gaps keep every anode dark so the previous digit's segment
      // pattern cannot ghost onto the next digit while drivers settle.
      default: begin
        an_nxt  = AN_OFF;
        seg_nxt = SEG_BLANK;
      end
    endcase
  end

  always_comb begin
    frame_nxt = (state == S_GAP2) && slot_last;
  end

  // ---------------------------------------------------------------------------
  // State, holding register and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      hold  <= 8'h00;
      state <= S_ONES;
      cnt   <= '0;
      seg   <= SEG_BLANK;
      an    <= AN_OFF;
      dp    <= 1'b1;
      frame <= 1'b0;
    end else begin
      if (load) begin
        hold <= bcd_in;
      end
      state <= state_nxt;
      cnt   <= slot_last ? '0 : cnt + 1'b1;
      seg   <= seg_nxt;
      an    <= an_nxt;
      dp    <= 1'b1;
      frame <= frame_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_display_mux.sv
// Purpose : directed self-checking bench for bcd_display_mux (REFRESH_DIV=4, GAP_CYCLES=1).
// Latency : outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
//
// Edge numbers in the comments count rising edges after reset release, with
// output phase p = (edge-1) mod 10: 0-3 ones, 4 gap1, 5-8 tens, 9 gap2.
// Build with LEADING_ZERO_BLANK_EN defined to check the blanking variant.
module tb_bcd_display_mux;

  logic       clk;
  logic       reset;
  logic [7:0] bcd_in;
  logic       load;
  logic [6:0] seg;
  logic       dp;
  logic [1:0] an;
  logic       frame;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  bcd_display_mux #(
    .REFRESH_DIV (4),
    .GAP_CYCLES  (1),
    .CNT_W       (16)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bcd_in (bcd_in),
    .load   (load),
    .seg    (seg),
    .dp     (dp),
    .an     (an),
    .frame  (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full scan of outputs with holding = 00, tens shown as "0"
  logic [1:0] exp_an    [10];
  logic [6:0] exp_seg   [10];
  logic       exp_frame [10];

  initial begin
    exp_an    = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b01, 2'b01, 2'b01, 2'b01, 2'b11};
    exp_seg   = '{7'h40, 7'h40, 7'h40, 7'h40, 7'h7F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h7F};
    exp_frame = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`ifdef LEADING_ZERO_BLANK_EN
    for (int i = 5; i < 9; i++) begin
      exp_an[i]  = 2'b11;
      exp_seg[i] = 7'h7F;
    end
`endif

    reset  = 1'b1;
    load   = 1'b0;
    bcd_in = 8'h00;

    // Reset held 3 cycles; a load on the last reset edge must be ignored
    tick();
    tick();
    load   = 1'b1;
    bcd_in = 8'h99;
    tick();
    chk("rst_an",    {6'd0, an},    8'h03);
    chk("rst_seg",   {1'b0, seg},   8'h7F);
    chk("rst_dp",    {7'd0, dp},    8'h01);
    chk("rst_frame", {7'd0, frame}, 8'h00);
    reset  = 1'b0;
    load   = 1'b0;
    bcd_in = 8'h00;

    // Edges 1-20: two full scans; also no an=00 and blank segments when dark
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("scan_an_%0d", i),    {6'd0, an},    {6'd0, exp_an[i % 10]});
      chk($sformatf("scan_seg_%0d", i),   {1'b0, seg},   {1'b0, exp_seg[i % 10]});
      chk($sformatf("scan_frame_%0d", i), {7'd0, frame}, {7'd0, exp_frame[i % 10]});
    end

    // Load 31 at edge 21 (output there still from old value 00)
    load   = 1'b1;
    bcd_in = 8'h31;
    tick();                                       // edge 21, ph0
    chk("ld31_latency", {1'b0, seg}, 8'h40);
    load   = 1'b0;
    bcd_in = 8'h77;                               // must not leak through
    tick();                                       // edge 22, ph1
    chk("ld31_ones_seg", {1'b0, seg}, 8'h79);
    chk("ld31_ones_an",  {6'd0, an},  8'h02);
    repeat (4) tick();                            // edge 26, ph5
    chk("ld31_tens_seg", {1'b0, seg}, 8'h30);
    chk("ld31_tens_an",  {6'd0, an},  8'h01);

    // Load 2A at edge 31: ones shows dash, tens shows 2
    repeat (4) tick();                            // edge 30, ph9
    load   = 1'b1;
    bcd_in = 8'h2A;
    tick();                                       // edge 31, ph0
    chk("ld2a_latency", {1'b0, seg}, 8'h79);
    load   = 1'b0;
    tick();                                       // edge 32, ph1
    chk("ld2a_ones_dash", {1'b0, seg}, 8'h3F);
    repeat (4) tick();                            // edge 36, ph5
    chk("ld2a_tens_seg", {1'b0, seg}, 8'h24);

    // Reload 31 mid tens slot (captured at edge 37)
    load   = 1'b1;
    bcd_in = 8'h31;
    tick();                                       // edge 37, ph6
    chk("mid_old_tens", {1'b0, seg}, 8'h24);
    load   = 1'b0;
    tick();                                       // edge 38, ph7
    chk("mid_new_tens", {1'b0, seg}, 8'h30);

    // Load 05 while tens slot shows 3 (captured at edge 47)
    repeat (8) tick();                            // edge 46, ph5
    chk("ld05_pre", {1'b0, seg}, 8'h30);
    load   = 1'b1;
    bcd_in = 8'h05;
    tick();                                       // edge 47, ph6
    chk("ld05_latency", {1'b0, seg}, 8'h30);
    load   = 1'b0;
    tick();                                       // edge 48, ph7
`ifdef LEADING_ZERO_BLANK_EN
    chk("ld05_tens_seg", {1'b0, seg}, 8'h7F);
    chk("ld05_tens_an",  {6'd0, an},  8'h03);
    tick();                                       // edge 49, ph8
    chk("ld05_tens_an2", {6'd0, an},  8'h03);
`else
    chk("ld05_tens_seg", {1'b0, seg}, 8'h40);
    chk("ld05_tens_an",  {6'd0, an},  8'h01);
    tick();                                       // edge 49, ph8
    chk("ld05_tens_an2", {6'd0, an},  8'h01);
`endif
    tick();                                       // edge 50, ph9
    chk("ld05_frame", {7'd0, frame}, 8'h01);
    tick();                                       // edge 51, ph0
    chk("ld05_ones_seg", {1'b0, seg}, 8'h12);

    // Reset during the second cycle of the tens slot, with a load alongside
    repeat (5) tick();                            // edge 56, ph5
    reset  = 1'b1;
    load   = 1'b1;
    bcd_in = 8'h99;
    tick();                                       // edge 57
    chk("midrst_an",  {6'd0, an},  8'h03);
    chk("midrst_seg", {1'b0, seg}, 8'h7F);
    reset  = 1'b0;
    load   = 1'b0;
    bcd_in = 8'h00;
    // Full 4-cycle ones slot showing 0 (holding cleared), then a gap
    for (int i = 0; i < 4; i++) begin
      tick();                                     // edges 58-61
      chk($sformatf("restart_an_%0d", i),  {6'd0, an},  8'h02);
      chk($sformatf("restart_seg_%0d", i), {1'b0, seg}, 8'h40);
    end
    tick();                                       // edge 62, gap1
    chk("restart_gap_an", {6'd0, an}, 8'h03);
    tick();                                       // edge 63, tens
`ifdef LEADING_ZERO_BLANK_EN
    chk("restart_tens_an", {6'd0, an}, 8'h03);
`else
    chk("restart_tens_an", {6'd0, an}, 8'h01);
`endif

    // Back-to-back loads across the next ones slot: 4, 6, 8, 9
    repeat (3) tick();                            // edge 66
    load   = 1'b1;
    bcd_in = 8'h04;
    tick();                                       // edge 67, gap2
    bcd_in = 8'h06;
    tick();                                       // edge 68, ph0
    chk("dec4", {1'b0, seg}, 8'h19);
    bcd_in = 8'h08;
    tick();                                       // edge 69
    chk("dec6", {1'b0, seg}, 8'h02);
    bcd_in = 8'h09;
    tick();                                       // edge 70
    chk("dec8", {1'b0, seg}, 8'h00);
    load   = 1'b0;
    tick();                                       // edge 71
    chk("dec9", {1'b0, seg}, 8'h10);
    chk("dec_dp", {7'd0, dp}, 8'h01);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
